// File: rtl/arbiter_out_fifo.sv
// rtl/arbiter_out_fifo.sv - registered output FIFO between the arbiter and its consumer
// Optional combinational empty-bypass is enabled by defining ARB_OUT_FIFO_BYPASS_EN.
module arbiter_out_fifo #(
  parameter int DWIDTH       = 16,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DWIDTH-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DWIDTH-1:0]            out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              stored_valid;
  logic              push;
  logic              pop;

  // All flags come from registered occupancy so in_ready never sees out_ready.
  assign stored_valid = (count_q != '0);
  assign in_ready     = (count_q != FULL_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign count        = count_q;
  assign pop          = stored_valid & out_ready;

`ifdef ARB_OUT_FIFO_BYPASS_EN
  logic bypass;
  assign bypass    = ~stored_valid & in_valid;
  assign out_valid = stored_valid | bypass;
  assign out_data  = bypass ? in_data : mem_q[rd_ptr_q];
  // A bypassed word taken by the consumer in the same cycle is never stored.
  assign push      = in_valid & in_ready & ~(bypass & out_ready);
`else
  assign out_valid = stored_valid;
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assert property (@(posedge clk) disable iff (rst) count_q <= FULL_C);

endmodule

// File: tb/tb_arbiter_out_fifo.sv
// tb/tb_arbiter_out_fifo.sv - self-checking bench for arbiter_out_fifo against a queue model
module tb_arbiter_out_fifo;

`ifdef ARB_OUT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        almost_full;

  int checks = 0;
  int fails  = 0;

  logic [15:0] mq[$];

  arbiter_out_fifo #(.DWIDTH(16), .DEPTH(4), .AFULL_THRESH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  function automatic bit m_byp();
    return BYP && (mq.size() == 0) && in_valid;
  endfunction
  function automatic int  m_cnt(); return mq.size(); endfunction
  function automatic bit  m_ir();  return mq.size() != 4; endfunction
  function automatic bit  m_af();  return mq.size() >= 3; endfunction
  function automatic bit  m_ov();  return (mq.size() != 0) || m_byp(); endfunction
  function automatic logic [15:0] m_od();
    return m_byp() ? in_data : mq[0];
  endfunction

  task automatic set_in(input bit iv, input logic [15:0] d, input bit ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Advance one clock edge and apply the FIFO rules to the model queue.
  task automatic tick();
    bit pu, po;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else if (!(m_byp() && out_ready)) begin
      po = (mq.size() != 0) && out_ready;
      pu = in_valid && (mq.size() != 4);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 16'h0, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd0)     begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    tick();
  endtask

  task automatic test_ordering();
    logic [15:0] exp_w;
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 16'(i), 1'b0);
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if (count !== 3'd3)       begin fails++; $display("FAIL order_count got=%0d exp=3", count); end
    checks++; if (almost_full !== 1'b1) begin fails++; $display("FAIL order_afull got=%b exp=1", almost_full); end
    checks++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL order_in_ready got=%b exp=1", in_ready); end
    tick();
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b0, 16'h0, 1'b1);
      exp_w = 16'(i);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_w)
        begin fails++; $display("FAIL order_word%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_w); end
      tick();
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || count !== 3'd0)
      begin fails++; $display("FAIL order_empty got=%b/%0d exp=0/0", out_valid, count); end
    set_in(1'b0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_full();
    logic [15:0] exp_w[$];
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h20 + 16'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 16'h00AA, 1'b0);
      @(negedge clk);
      checks++; if (count !== 3'd4 || in_ready !== 1'b0)
        begin fails++; $display("FAIL full_hold got=%0d/%b exp=4/0", count, in_ready); end
      tick();
    end
    set_in(1'b1, 16'h00AA, 1'b1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_data !== 16'h20)
      begin fails++; $display("FAIL full_pop_cycle got=%b/%h exp=0/0020", in_ready, out_data); end
    tick();
    set_in(1'b1, 16'h00AA, 1'b0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || count !== 3'd3)
      begin fails++; $display("FAIL full_bubble got=%b/%0d exp=1/3", in_ready, count); end
    tick();
    exp_w = '{16'h21, 16'h22, 16'h23, 16'hAA};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 16'h0, 1'b1);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_w[i])
        begin fails++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_w[i]); end
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 16'h0E + 16'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 16'h10 + 16'(i), 1'b1);
      @(negedge clk);
      checks++; if (count !== 3'd2 || out_valid !== 1'b1 || in_ready !== 1'b1)
        begin fails++; $display("FAIL b2b_flags%0d got=%0d/%b/%b exp=2/1/1", i, count, out_valid, in_ready); end
      checks++; if (out_data !== m_od())
        begin fails++; $display("FAIL b2b_data%0d got=%h exp=%h", i, out_data, m_od()); end
      tick();
    end
    while (mq.size() != 0) begin
      set_in(1'b0, 16'h0, 1'b1);
      @(negedge clk);
      checks++; if (out_data !== m_od())
        begin fails++; $display("FAIL b2b_drain got=%h exp=%h", out_data, m_od()); end
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] seen[$];
    int sent = 0;
    int cyc  = 0;
    while ((sent < 10 || mq.size() != 0) && cyc < 400) begin
      set_in((sent < 10) && ($urandom_range(0, 3) != 0), 16'h0100 + 16'(sent), $urandom_range(0, 1) == 1);
      @(negedge clk);
      if (out_valid && out_ready) seen.push_back(out_data);
      if (in_valid && m_ir() && !(m_byp() && out_ready)) sent++;
      else if (m_byp() && out_ready) sent++;
      tick();
      cyc++;
    end
    checks++; if (cyc >= 400) begin fails++; $display("FAIL wrap_timeout got=%0d exp<400", cyc); end
    checks++; if (seen.size() != 10) begin fails++; $display("FAIL wrap_len got=%0d exp=10", seen.size()); end
    for (int i = 0; i < 10 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== 16'h0100 + 16'(i))
        begin fails++; $display("FAIL wrap_word%0d got=%h exp=%h", i, seen[i], 16'h0100 + 16'(i)); end
    end
    set_in(1'b0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++; if (count !== 3'(m_cnt()) || in_ready !== m_ir() || almost_full !== m_af() || out_valid !== m_ov())
        begin fails++; $display("FAIL rand_flags%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/%b", i, count, in_ready, almost_full, out_valid, m_cnt(), m_ir(), m_af(), m_ov()); end
      if (m_ov()) begin
        checks++; if (out_data !== m_od())
          begin fails++; $display("FAIL rand_data%0d got=%h exp=%h", i, out_data, m_od()); end
      end
      tick();
    end
    while (mq.size() != 0) begin
      set_in(1'b0, 16'h0, 1'b1);
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'h30 + 16'(i), 1'b0);
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || almost_full !== 1'b0)
      begin fails++; $display("FAIL midrst_state got=%0d/%b/%b/%b exp=0/0/1/0", count, out_valid, in_ready, almost_full); end
    set_in(1'b1, 16'h0055, 1'b0);
    tick();
    set_in(1'b0, 16'h0, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0055)
      begin fails++; $display("FAIL midrst_first got=%b/%h exp=1/0055", out_valid, out_data); end
    tick();
    set_in(1'b0, 16'h0, 1'b0);
    tick();
  endtask

  task automatic test_bypass();
    set_in(1'b1, 16'h0077, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== BYP)
      begin fails++; $display("FAIL byp_valid got=%b exp=%b", out_valid, BYP); end
    if (BYP) begin
      checks++; if (out_data !== 16'h0077)
        begin fails++; $display("FAIL byp_data got=%h exp=0077", out_data); end
    end
    tick();
    set_in(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if (count !== (BYP ? 3'd0 : 3'd1))
      begin fails++; $display("FAIL byp_count got=%0d exp=%0d", count, BYP ? 0 : 1); end
    if (!BYP) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0077)
        begin fails++; $display("FAIL byp_next got=%b/%h exp=1/0077", out_valid, out_data); end
    end
    set_in(1'b0, 16'h0, 1'b1);
    tick();
    set_in(1'b0, 16'h0, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 16'h0, 1'b0);
    test_reset();
    test_ordering();
    test_full();
    test_back_to_back();
    test_wrap();
    test_random();
    test_midreset();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
